// File: rtl/lcd_hex_panel.sv
// lcd_hex_panel: HD44780 16x2 driver that runs power-on init, then refreshes two labelled hex fields.
// Optional LCD_ZERO_BLANK_EN blanks leading zero digits of each field.
module lcd_hex_panel #(
    parameter int          DATA_W      = 32,
    parameter logic [63:0] LABEL0      = "Output: ",
    parameter logic [63:0] LABEL1      = "PC:     ",
    parameter int          PWR_CYC     = 750000,
    parameter int          EN_CYC      = 16,
    parameter int          CMD_CYC     = 2500,
    parameter int          CLR_CYC     = 100000,
    parameter int          REFRESH_CYC = 2500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] val0,
    input  logic [DATA_W-1:0] val1,
    output logic [7:0]        lcd_data,
    output logic              lcd_rs,
    output logic              lcd_rw,
    output logic              lcd_en,
    output logic              init_done,
    output logic              frame_done
);
    localparam int ND   = DATA_W / 4;
    localparam int MX0  = PWR_CYC > CLR_CYC ? PWR_CYC : CLR_CYC;
    localparam int MAXC = MX0 > REFRESH_CYC ? MX0 : REFRESH_CYC;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] PWR_LAST = CW'(PWR_CYC - 1);
    localparam logic [CW-1:0] EN_LAST  = CW'(EN_CYC - 1);
    localparam logic [CW-1:0] CMD_LAST = CW'(CMD_CYC - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYC - 1);
    localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_CYC - 1);

    generate
        if (DATA_W % 4 != 0 || DATA_W < 4 || DATA_W > 32) begin : g_bad_width
            $error("lcd_hex_panel: DATA_W must be a multiple of 4 in 4..32");
        end
    endgenerate

    typedef enum logic [2:0] {PWR, SETUP, ASU, ENH, HOLD, IDLE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [5:0]        idx_q, idx_d;
    logic              init_done_q, init_done_d;
    logic              frame_done_q, frame_done_d;
    logic [DATA_W-1:0] snap0_q, snap0_d, snap1_q, snap1_d;
    logic [7:0]        lcd_data_q, lcd_data_d;
    logic              lcd_rs_q, lcd_rs_d;
    logic              lcd_en_q, lcd_en_d;
    logic [CW-1:0]     w_last;

    function automatic logic [7:0] hex_char(input logic [DATA_W-1:0] v, input int k);
        int          p;
        logic [31:0] sh;
        p  = 7 - k;
        sh = 32'(v >> (4 * p));
        if (k < 8 - ND) return 8'h20;
`ifdef LCD_ZERO_BLANK_EN
        if (p != 0 && sh == 32'd0) return 8'h20;
`endif
        return sh[3:0] < 4'd10 ? 8'h30 + 8'(sh[3:0]) : 8'h37 + 8'(sh[3:0]);
    endfunction

    // Returns {rs, byte} for list position i of the init list or the frame list.
    function automatic logic [8:0] list_byte(input logic in_frame, input logic [5:0] i,
                                             input logic [DATA_W-1:0] s0, input logic [DATA_W-1:0] s1);
        int   c;
        logic line2;
        if (!in_frame)
            return {1'b0, i[1:0] == 2'd0 ? 8'h38 : i[1:0] == 2'd1 ? 8'h0C : i[1:0] == 2'd2 ? 8'h01 : 8'h06};
        if (i == 6'd0) return 9'h080;
        if (i == 6'd17) return 9'h0C0;
        line2 = i > 6'd17;
        c     = line2 ? int'(i) - 18 : int'(i) - 1;
        if (c < 8) return {1'b1, line2 ? LABEL1[63 - 8*c -: 8] : LABEL0[63 - 8*c -: 8]};
        return {1'b1, hex_char(line2 ? s1 : s0, c - 8)};
    endfunction

    assign w_last = (!lcd_rs_q && lcd_data_q == 8'h01) ? CLR_LAST : CMD_LAST;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        idx_d        = idx_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        snap0_d      = snap0_q;
        snap1_d      = snap1_q;
        lcd_data_d   = lcd_data_q;
        lcd_rs_d     = lcd_rs_q;
        case (state_q)
            PWR: if (cnt_q == PWR_LAST) begin
                state_d = SETUP;
                cnt_d   = '0;
                idx_d   = '0;
            end
            SETUP: begin
                state_d = ASU;
                cnt_d   = '0;
            end
            ASU: begin
                state_d = ENH;
                cnt_d   = '0;
            end
            ENH: if (cnt_q == EN_LAST) begin
                state_d = HOLD;
                cnt_d   = '0;
            end
            HOLD: if (cnt_q == w_last) begin
                cnt_d = '0;
                if (!init_done_q) begin
                    state_d     = SETUP;
                    idx_d       = idx_q == 6'd3 ? 6'd0 : idx_q + 6'd1;
                    init_done_d = idx_q == 6'd3;
                end else if (idx_q == 6'd33) begin
                    state_d      = IDLE;
                    idx_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    state_d = SETUP;
                    idx_d   = idx_q + 6'd1;
                end
            end
            IDLE: if (cnt_q == REF_LAST) begin
                state_d = SETUP;
                cnt_d   = '0;
            end
            default: state_d = PWR;
        endcase
        // Both values are captured together as f0 starts so a frame never mixes old and new data.
        if (state_d == SETUP) begin
            {lcd_rs_d, lcd_data_d} = list_byte(init_done_d, idx_d, snap0_q, snap1_q);
            if (init_done_d && idx_d == 6'd0) begin
                snap0_d = val0;
                snap1_d = val1;
            end
        end
        lcd_en_d = state_d == ENH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= PWR;
            cnt_q        <= '0;
            idx_q        <= '0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            snap0_q      <= '0;
            snap1_q      <= '0;
            lcd_data_q   <= '0;
            lcd_rs_q     <= 1'b0;
            lcd_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
            snap0_q      <= snap0_d;
            snap1_q      <= snap1_d;
            lcd_data_q   <= lcd_data_d;
            lcd_rs_q     <= lcd_rs_d;
            lcd_en_q     <= lcd_en_d;
        end
    end

    assign lcd_data   = lcd_data_q;
    assign lcd_rs     = lcd_rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_en     = lcd_en_q;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_lcd_hex_panel.sv
// tb_lcd_hex_panel: directed bench for lcd_hex_panel with a 32-bit and a 16-bit instance in lockstep.
module tb_lcd_hex_panel;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] val0 = '0, val1 = '0;
    logic [15:0] v16 = '0;
    logic [7:0]  lcd_data, d16;
    logic        lcd_rs, lcd_rw, lcd_en, init_done, frame_done;
    logic        rs16, rw16, en16, id16, fd16;

    always #5 clk = ~clk;

    lcd_hex_panel #(.DATA_W(32), .PWR_CYC(10), .EN_CYC(2), .CMD_CYC(4), .CLR_CYC(8), .REFRESH_CYC(20)) dut (
        .clk(clk), .rst(rst), .val0(val0), .val1(val1), .lcd_data(lcd_data), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .lcd_en(lcd_en), .init_done(init_done), .frame_done(frame_done));

    lcd_hex_panel #(.DATA_W(16), .PWR_CYC(10), .EN_CYC(2), .CMD_CYC(4), .CLR_CYC(8), .REFRESH_CYC(20)) dut16 (
        .clk(clk), .rst(rst), .val0(v16), .val1(16'h0000), .lcd_data(d16), .lcd_rs(rs16),
        .lcd_rw(rw16), .lcd_en(en16), .init_done(id16), .frame_done(fd16));

    typedef struct {
        logic [31:0] v0, v1;
        logic [15:0] v16;
        string       e0, e1, e16;
    } vec_t;

    int   n_chk = 0, n_pass = 0;
    int   cyc;
    int   rq[$], fq[$], fdq[$];
    int   bq[$], q16[$];
    int   init_rise = -1, fd_run = 0, fd_max = 0;
    logic en_p = 1'b0, en16_p = 1'b0;

    always @(posedge clk or posedge rst)
        if (rst) cyc <= 0;
        else cyc <= cyc + 1;

    // Write log: rise/fall cycle and {rs,data} of every enable strobe.
    always @(negedge clk) begin
        if (rst) begin
            rq.delete(); fq.delete(); bq.delete(); q16.delete(); fdq.delete();
            init_rise = -1; fd_run = 0; fd_max = 0; en_p = 1'b0; en16_p = 1'b0;
        end else begin
            if (lcd_en && !en_p) begin
                rq.push_back(cyc);
                bq.push_back(int'({lcd_rs, lcd_data}));
            end
            if (!lcd_en && en_p) fq.push_back(cyc);
            if (en16 && !en16_p) q16.push_back(int'({rs16, d16}));
            en_p   = lcd_en;
            en16_p = en16;
            if (init_done && init_rise < 0) init_rise = cyc;
            if (frame_done) begin
                if (fd_run == 0) fdq.push_back(cyc);
                fd_run++;
                if (fd_run > fd_max) fd_max = fd_run;
            end else fd_run = 0;
        end
    end

    task automatic chki(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    endtask

    task automatic chks(input string nm, input string got, input string exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got \"%s\", expected \"%s\"", nm, got, exp);
    endtask

    task automatic wait_writes(input int n);
        for (int i = 0; i < 2000 && bq.size() < n; i++) begin
            @(negedge clk);
            #1;
        end
        chki("write_timeout", int'(bq.size() >= n), 1);
    endtask

    task automatic wait_frame(output int s, output int t);
        int n0 = fdq.size();
        for (int i = 0; i < 1000 && fdq.size() <= n0; i++) begin
            @(negedge clk);
            #1;
        end
        chki("frame_timeout", int'(fdq.size() > n0), 1);
        t = fdq.size() > 0 ? fdq[fdq.size()-1] : 0;
        s = bq.size() - 34;
    endtask

    task automatic check_init();
        int ib[4]  = '{'h038, 'h00C, 'h001, 'h006};
        int per[4] = '{8, 8, 12, 8};
        wait_writes(5);
        chki("pwr_delay", rq[0], 12);
        for (int i = 0; i < 4; i++) begin
            chki($sformatf("init_byte%0d", i), bq[i], ib[i]);
            chki($sformatf("init_en_width%0d", i), fq[i] - rq[i], 2);
            chki($sformatf("init_period%0d", i), rq[i+1] - rq[i], per[i]);
        end
        chki("init_done_rise", init_rise, 46);
        chki("init_then_f0", bq[4], 'h080);
    endtask

    task automatic check_frame(input int s, input vec_t v, input string tag);
        string g1 = "", g2 = "", g16 = "";
        int    rsn = 0;
        for (int i = 0; i < 16; i++) begin
            g1  = $sformatf("%s%c", g1, bq[s+1+i][7:0]);
            g2  = $sformatf("%s%c", g2, bq[s+18+i][7:0]);
            g16 = $sformatf("%s%c", g16, q16[s+1+i][7:0]);
            rsn += bq[s+1+i][8] + bq[s+18+i][8];
        end
        chki({tag, "_f0"}, bq[s], 'h080);
        chki({tag, "_f17"}, bq[s+17], 'h0C0);
        chks({tag, "_line1"}, g1, {"Output: ", v.e0});
        chks({tag, "_line2"}, g2, {"PC:     ", v.e1});
        chks({tag, "_line1_w16"}, g16, {"Output: ", v.e16});
        chki({tag, "_rs_data"}, rsn, 32);
    endtask

    initial begin
        vec_t  vec[3];
        vec_t  r;
        string z8, z16;
        int    s, t, cur;
`ifdef LCD_ZERO_BLANK_EN
        vec[0] = '{32'h1234ABCD, 32'h00400000, 16'hBEEF, "1234ABCD", "  400000", "    BEEF"};
        vec[1] = '{32'h000000A0, 32'h00000000, 16'h0000, "      A0", "       0", "       0"};
        vec[2] = '{32'hFFFFFFFF, 32'h9ABCDEF0, 16'h0123, "FFFFFFFF", "9ABCDEF0", "     123"};
        z8  = "       0";
        z16 = "       0";
`else
        vec[0] = '{32'h1234ABCD, 32'h00400000, 16'hBEEF, "1234ABCD", "00400000", "    BEEF"};
        vec[1] = '{32'h000000A0, 32'h00000000, 16'h0000, "000000A0", "00000000", "    0000"};
        vec[2] = '{32'hFFFFFFFF, 32'h9ABCDEF0, 16'h0123, "FFFFFFFF", "9ABCDEF0", "    0123"};
        z8  = "00000000";
        z16 = "    0000";
`endif
        repeat (3) @(negedge clk);
        chki("rst_data", lcd_data, 0);
        chki("rst_rs", lcd_rs, 0);
        chki("rst_rw", lcd_rw, 0);
        chki("rst_en", lcd_en, 0);
        chki("rst_init_done", init_done, 0);
        chki("rst_frame_done", frame_done, 0);
        rst = 1'b0;
        check_init();

        wait_frame(s, t);
        chki("first_frame_start", s, 4);
        wait_writes(s + 35);
        chki("idle_gap", rq[s+34] - t, 22);
        chki("idle_next_f0", bq[s+34], 'h080);
        wait_frame(s, t);

        for (int i = 0; i < 3; i++) begin
            val0 = vec[i].v0;
            val1 = vec[i].v1;
            v16  = vec[i].v16;
            wait_frame(s, t);
            check_frame(s, vec[i], $sformatf("vec%0d", i));
        end
        chki("frame_done_width", fd_max, 1);

        // Value change in the middle of line 1 must only show in the following frame.
        val0 = 32'h11111111;
        val1 = '0;
        v16  = '0;
        wait_frame(s, t);
        r = '{32'h0, 32'h0, 16'h0, "11111111", z8, z16};
        check_frame(s, r, "pre_change");
        cur = bq.size();
        wait_writes(cur + 6);
        val0 = 32'h22222222;
        wait_frame(s, t);
        chki("tear_frame_start", s, cur);
        check_frame(s, r, "no_tear");
        wait_frame(s, t);
        r.e0 = "22222222";
        check_frame(s, r, "next_frame");

        cur = bq.size();
        wait_writes(cur + 6);
        chki("en_before_rst", lcd_en, 1);
        rst = 1'b1;
        #1;
        chki("en_async_rst", lcd_en, 0);
        chki("init_done_async_rst", init_done, 0);
        chki("data_async_rst", lcd_data, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_init();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
